// File: rtl/Counter_pkg.sv
// Counter_pkg: shared types for the countdown counter (control bundle and FSM states).
package Counter_pkg;
  typedef struct packed {
    logic Clock;
    logic Reset;
  } Data_Control_Control_T;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_e;
endpackage

// File: rtl/counter_countdown.sv
// counter_countdown: reloadable one-shot/periodic down counter with terminal-count pulse.
module counter_countdown
  import Counter_pkg::*;
#(
  parameter int MAX = 12,
  parameter int W   = $clog2(MAX + 1)
) (
  input  Data_Control_Control_T ctrl,
  input  logic [W-1:0]          d,
  input  logic                  load,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  enable,
  input  logic                  periodic,
  output logic [W-1:0]          q,
  output logic                  busy,
  output logic                  done
);
  localparam logic [W-1:0] MAX_W = W'(MAX);
  logic         clk;
  logic         rst_n;
  state_e       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
  logic         done_q, done_d;
  logic [W-1:0] r_fwd;
  assign clk   = ctrl.Clock;
  assign rst_n = ctrl.Reset;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end
  // A load on the same edge as a start or reload wins over the stored value.
  always_comb begin
    r_fwd   = load ? (d > MAX_W ? MAX_W : d) : r_q;
    r_d     = r_fwd;
    state_d = state_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      q_d     = '0;
    end else if (state_q != RUN) begin
      if (start) begin
        q_d     = r_fwd;
        state_d = RUN;
      end
    end else if (enable) begin
      if (q_q > W'(1)) begin
        q_d = q_q - W'(1);
      end else begin
        done_d  = 1'b1;
        q_d     = periodic ? r_fwd : '0;
        state_d = periodic ? RUN : EXPIRED;
      end
    end
  end
  assign q    = q_q;
  assign done = done_q;
  assign busy = (state_q == RUN);
endmodule

// File: tb/tb_counter_countdown.sv
// tb_counter_countdown: directed checks of clamp, one-shot, periodic, hold/stop, forwarding and async reset.
module tb_counter_countdown;
  import Counter_pkg::*;
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  Data_Control_Control_T ctrl;
  logic [3:0]            d = '0;
  logic                  load = 1'b0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic                  enable = 1'b0;
  logic                  periodic = 1'b0;
  logic [3:0]            q;
  logic                  busy;
  logic                  done;
  int                    errors = 0;
  int                    checks = 0;
  assign ctrl = '{Clock: clk, Reset: rst_n};
  counter_countdown #(.MAX(12)) dut (
    .ctrl(ctrl), .d(d), .load(load), .start(start), .stop(stop),
    .enable(enable), .periodic(periodic), .q(q), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  task automatic do_load(input logic [3:0] v);
    d    = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  initial begin
    logic [3:0] pq[6];
    logic       pd[6];
    int         npulse;
    pq = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    pd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    #3;
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #9 rst_n = 1'b1;
    tick();
    check("idle_after_rst", busy, 0);
    do_load(4'd15);
    check("load_no_start", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clamp15_q", q, 12);
    check("clamp15_busy", busy, 1);
    do_stop();
    do_load(4'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load5_q", q, 5);
    do_stop();
    do_load(4'd3);
    enable   = 1'b1;
    periodic = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("os_q3", q, 3);
    check("os_d3", done, 0);
    tick();
    check("os_q2", q, 2);
    check("os_d2", done, 0);
    tick();
    check("os_q1", q, 1);
    check("os_d1", done, 0);
    tick();
    check("os_q0", q, 0);
    check("os_done", done, 1);
    check("os_exp_busy", busy, 0);
    tick();
    check("os_done_once", done, 0);
    check("os_q_stays0", q, 0);
    do_load(4'd2);
    periodic = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("per_q_start", q, 2);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("per_q%0d", i), q, pq[i]);
      check($sformatf("per_d%0d", i), done, pd[i]);
      npulse += int'(done);
    end
    check("per_pulses", npulse, 3);
    check("per_busy", busy, 1);
    do_stop();
    check("per_stop_busy", busy, 0);
    do_load(4'd10);
    periodic = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("hold_pre_q", q, 7);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_q%0d", i), q, 7);
      check($sformatf("hold_d%0d", i), done, 0);
    end
    start = 1'b1;
    enable = 1'b1;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check("stop_q", q, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    d     = 4'd4;
    load  = 1'b1;
    start = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check("fwd_start_q", q, 4);
    do_stop();
    do_load(4'd2);
    periodic = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("fwd_tc_pre", q, 1);
    d    = 4'd9;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("fwd_tc_q", q, 9);
    check("fwd_tc_done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_ignored", q, 8);
    do_stop();
    do_load(4'd0);
    periodic = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("r0_q", q, 0);
    check("r0_busy", busy, 1);
    check("r0_nodone", done, 0);
    tick();
    check("r0_done", done, 1);
    check("r0_exp", busy, 0);
    do_load(4'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ar_pre_q", q, 6);
    #2 rst_n = 1'b0;
    #1;
    check("ar_q", q, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    tick();
    check("ar_hold_q", q, 0);
    check("ar_hold_done", done, 0);
    #2 rst_n = 1'b1;
    tick();
    check("ar_release_idle", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ar_r_cleared", q, 0);
    check("ar_start_busy", busy, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/counter_countdown.md
COUNTER_COUNTDOWN -- requirements
Module: Counter_countdown

Interface
REQ-001 SHALL have parameter MAX, default 12, giving the largest reload value.
REQ-002 SHALL have derived parameter W = $clog2(MAX+1), default 4, giving the counter width.
REQ-003 SHALL have port ctrl, input, Data_Control_Control_T, the control bundle; the Clock field is the one clock and all state changes on its rising edge.
REQ-004 SHALL take reset from the Reset field of ctrl; reset is asynchronous and active-low (0 = in reset).
REQ-005 SHALL have port d, input, W bits, the reload value.
REQ-006 SHALL have port load, input, 1 bit; when high, d is captured into the reload register R.
REQ-007 SHALL have port start, input, 1 bit, which begins a countdown.
REQ-008 SHALL have port stop, input, 1 bit, which aborts a countdown.
REQ-009 SHALL have port enable, input, 1 bit; counting advances only while it is high.
REQ-010 SHALL have port periodic, input, 1 bit; 1 = auto-reload mode, 0 = one-shot mode.
REQ-011 SHALL have port q, output, W bits, the current count.
REQ-012 SHALL have port busy, output, 1 bit, high while in state RUN.
REQ-013 SHALL have port done, output, 1 bit, a one-cycle terminal-count pulse.

Function
REQ-014 SHALL implement states IDLE, RUN and EXPIRED.
REQ-015 SHALL, on a load edge, write R <= (d > MAX ? MAX : d), in any state.
REQ-016 SHALL, when load and start are both high, use the clamped d that same edge (forwarded), not the old R.
REQ-017 SHALL, on start in IDLE or EXPIRED, set q <= R and go to RUN; start in RUN is ignored.
REQ-018 SHALL, in RUN with enable=1 and q>1, set q <= q-1.
REQ-019 SHALL, in RUN with enable=1 and q==1, register done=1 for exactly one cycle, coincident with the edge on which q leaves 1.
REQ-020 SHALL, in that q==1 case with periodic=0, set q <= 0 and go to EXPIRED.
REQ-021 SHALL, in that q==1 case with periodic=1, set q <= R (using the forwarded d if load is high), stay in RUN, and give a period of R enabled cycles.
REQ-022 SHALL, in RUN with enable=0, hold q and keep done=0.
REQ-023 SHALL handle a start with R==0: one-shot gives q=0, a done pulse, then EXPIRED; periodic gives q=0 and done on every enabled cycle until stop.
REQ-024 SHALL, on stop in any state, set q <= 0 and go to IDLE with no done pulse; stop has priority over start and the count.
REQ-025 SHALL sample the periodic input only at the terminal count.
REQ-026 SHALL drive busy = (state==RUN) combinationally from state.
REQ-027 SHALL never let q exceed MAX and never let q wrap below 0.

Reset
REQ-028 SHALL, while Reset=0, force q=0, R=0, state IDLE, done=0 and busy=0, asynchronously.
REQ-029 SHALL, on reset release, leave IDLE only on start.
REQ-030 SHALL abort a countdown immediately if reset asserts mid-RUN, with no done pulse.

Structure
REQ-031 SHALL place the state enum (IDLE/RUN/EXPIRED) in shared package Counter_pkg, beside any other Counter typedefs.
REQ-032 SHALL have no sub-module; the clamp and next-state logic are inline, using one always_ff and one always_comb.

Verification (MAX=12)
REQ-033 SHALL verify clamp: load with d=15, then start, gives q=12 the next cycle; load with d=5 gives R=5.
REQ-034 SHALL verify one-shot: R=3, start, enable=1 gives q=3,2,1,0; done high exactly on the cycle q becomes 0; then EXPIRED with busy=0.
REQ-035 SHALL verify periodic: R=2, periodic=1, enable=1 for 6 cycles gives q=2,1,2,1,2,1 with 3 done pulses.
REQ-036 SHALL verify hold and stop: enable=0 mid-count holds q=7 for 4 cycles with no done; then stop gives q=0, IDLE, no done.
REQ-037 SHALL verify simultaneous events: load d=4 together with start gives q=4; load d=9 coinciding with a periodic terminal count gives q=9.
REQ-038 SHALL verify async reset: Reset=0 driven between clock edges during RUN with q=6 gives q=0 and busy=0 before the next edge; done stays 0.
